// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI word width and receiver state encoding
package spi_pkg;
  localparam int SPI_WORD_W = 16;

  typedef enum logic {RX_IDLE, RX_SHIFT} spi_rx_state_t;
  typedef logic [SPI_WORD_W-1:0] spi_word_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead single-clock FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // head_q keeps the last presented word visible once the FIFO drains
  assign rdata = empty ? head_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (!empty) head_q <= mem[rd_ptr];
    end
  end
endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - oversampled SPI receiver with idle-timeout framing and word FIFO
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WORD_W       = SPI_WORD_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          mosi,
  output logic [WORD_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overflow,
  output logic                          frag_drop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   s_sclk_q;
  logic                   s_sclk;
  logic                   s_mosi;
  logic                   rise;
  logic                   sclk_edge;

  logic [TW-1:0]          idle_cnt;
  logic                   timeout;

  spi_rx_state_t          state;
  logic [CW-1:0]          bit_cnt;
  logic [WORD_W-1:0]      shift_q;
  logic                   push_valid;
  logic [WORD_W-1:0]      push_data;

  logic                   fifo_full;
  logic                   fifo_empty;

  // equal-depth chains keep mosi aligned with the sclk edge it belongs to
  assign s_sclk    = sclk_sync[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync[SYNC_STAGES-1];
  assign rise      = s_sclk & ~s_sclk_q;
  assign sclk_edge = s_sclk ^ s_sclk_q;
  assign timeout   = (idle_cnt == TW'(IDLE_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      s_sclk_q  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      s_sclk_q  <= s_sclk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            idle_cnt <= '0;
    else if (sclk_edge) idle_cnt <= '0;
    else if (!timeout)  idle_cnt <= idle_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      push_valid <= 1'b0;
      push_data  <= '0;
      frag_drop  <= 1'b0;
    end else begin
      push_valid <= 1'b0;
      frag_drop  <= 1'b0;
      case (state)
        RX_IDLE: begin
          bit_cnt <= '0;
          if (rise) begin
            shift_q <= {shift_q[WORD_W-2:0], s_mosi};
            bit_cnt <= CW'(1);
            state   <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (rise) begin
            shift_q <= {shift_q[WORD_W-2:0], s_mosi};
            if (bit_cnt == CW'(WORD_W - 1)) begin
              push_valid <= 1'b1;
              push_data  <= {shift_q[WORD_W-2:0], s_mosi};
              bit_cnt    <= '0;
              state      <= RX_IDLE;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (timeout) begin
            // master went quiet mid-word: the fragment cannot be framed, drop it
            bit_cnt   <= '0;
            shift_q   <= '0;
            frag_drop <= 1'b1;
            state     <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (push_valid && fifo_full && !(rx_valid && rx_ready))
      overflow <= 1'b1;
  end

  assign rx_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_valid),
    .wdata (push_data),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
endmodule
